icache_direct: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 4 +
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_direct_frame_array.sv | 46 ++++
 rtl/icache_direct.sv | 125 ++++++++++++
 tb/tb_icache_direct.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath types used across the CPU memory hierarchy.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_pkg.sv
// Types and geometry constants for the direct-mapped instruction cache.
package icache_pkg;
    import cpu_types_pkg::*;

    localparam int ICACHE_NSETS = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_NSETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;
    // Widest tag any legal geometry can need (NSETS >= 2); narrower tags are zero-extended.
    localparam int TAG_MAX_W    = 29;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        word_t                data;
    } icache_frame_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              off;
    } icache_addr_t;
endpackage

// File: rtl/icache_direct_frame_array.sv
// Frame storage for icache_direct: valid bits cleared by async reset,
// tag/data arrays unreset, one combinational read port and one synchronous write port.
module icache_frame_array
    import cpu_types_pkg::*;
    import icache_pkg::*;
#(
    parameter  int NSETS = ICACHE_NSETS,
    localparam int IDX_W = $clog2(NSETS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     ridx_i,
    output icache_frame_t        rframe_o,
    input  logic                 wen_i,
    input  logic [IDX_W-1:0]     widx_i,
    input  icache_frame_t        wframe_i
);

    logic [NSETS-1:0]     valid_q;
    logic [TAG_MAX_W-1:0] tag_q  [NSETS];
    word_t                data_q [NSETS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (wen_i) begin
            valid_q[widx_i] <= wframe_i.valid;
        end
    end

    // Payload needs no reset: a frame is only observed through its valid bit.
    always_ff @(posedge clk_i) begin
        if (wen_i) begin
            tag_q[widx_i]  <= wframe_i.tag;
            data_q[widx_i] <= wframe_i.data;
        end
    end

    always_comb begin
        rframe_o       = '0;
        rframe_o.valid = valid_q[ridx_i];
        rframe_o.tag   = tag_q[ridx_i];
        rframe_o.data  = data_q[ridx_i];
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache with a single-word fill FSM.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module icache_direct
    import cpu_types_pkg::*;
    import icache_pkg::*;
#(
    parameter int NSETS = ICACHE_NSETS
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
`ifdef ICACHE_STATS_EN
    ,
    output word_t hit_count,
    output word_t miss_count
`endif
);

    localparam int IDX_W = $clog2(NSETS);

    icache_state_t state_q;
    word_t         miss_addr_q;
    logic          iren_q;

    icache_frame_t rframe;
    icache_frame_t wframe;
    logic          wen;
    logic          hit;
    logic          miss_start;
    logic [TAG_MAX_W-1:0] req_tag;
    logic          unused_off;

    assign req_tag = TAG_MAX_W'(imemaddr[31:IDX_W+2]);

    icache_frame_array #(
        .NSETS (NSETS)
    ) u_frames (
        .clk_i    (CLK),
        .rst_i    (RST),
        .ridx_i   (imemaddr[IDX_W+1:2]),
        .rframe_o (rframe),
        .wen_i    (wen),
        .widx_i   (miss_addr_q[IDX_W+1:2]),
        .wframe_i (wframe)
    );

    assign hit        = (state_q == IDLE) && imemREN && rframe.valid && (rframe.tag == req_tag);
    assign miss_start = (state_q == IDLE) && imemREN && !hit;

    assign ihit     = hit;
    assign imemload = hit ? rframe.data : '0;
    assign iREN     = iren_q;
    // miss_addr_q is zero outside FILL, so it doubles as the registered iaddr.
    assign iaddr    = miss_addr_q;

    assign wen = (state_q == FILL) && !iwait;

    always_comb begin
        wframe       = '0;
        wframe.valid = 1'b1;
        wframe.tag   = TAG_MAX_W'(miss_addr_q[31:IDX_W+2]);
        wframe.data  = iload;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            iren_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_start) begin
                        miss_addr_q <= {imemaddr[31:2], 2'b00};
                        iren_q      <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    // Redirects and imemREN drops are ignored: the fill always lands.
                    if (!iwait) begin
                        miss_addr_q <= '0;
                        iren_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    word_t hit_cnt_q;
    word_t miss_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    assign unused_off = ^{imemaddr[1:0], miss_addr_q[1:0]};

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios plus random fetches against an array-based cache model.
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_direct dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Reference cache: 16 frames, word address split by plain division.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_data  [16];
    int unsigned m_hits;
    int unsigned m_miss;

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] a);
        return a / 64;
    endfunction

    function automatic logic [31:0] memval(input logic [31:0] a);
        logic [31:0] w;
        w = (a / 4) * 4;
        if (w == 32'h40) return 32'h8C220004;
        return (w * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic request(input logic [31:0] a, output bit h);
        imemREN  = 1'b1;
        imemaddr = a;
        #1;
        h = m_hit(a);
        chk("iREN_idle", {31'b0, iREN}, 32'd0);
        if (h) begin
            chk("ihit_hit", {31'b0, ihit}, 32'd1);
            chk("imemload_hit", imemload, m_data[m_idx(a)]);
            m_hits++;
        end else begin
            chk("ihit_miss", {31'b0, ihit}, 32'd0);
            m_miss++;
        end
    endtask

    task automatic fill(input logic [31:0] a, input int lat);
        for (int k = 0; k <= lat; k++) begin
            iwait = (k < lat);
            iload = (k < lat) ? $urandom : memval(a);
            #1;
            chk("iREN_fill", {31'b0, iREN}, 32'd1);
            chk("iaddr_fill", iaddr, (a / 4) * 4);
            chk("ihit_fill", {31'b0, ihit}, 32'd0);
            cyc();
        end
        iwait = 1'b1;
        m_valid[m_idx(a)] = 1'b1;
        m_tag[m_idx(a)]   = m_tagof(a);
        m_data[m_idx(a)]  = memval(a);
    endtask

    task automatic fetch(input logic [31:0] a, input int lat);
        bit h;
        request(a, h);
        cyc();
        if (!h) begin
            fill(a, lat);
            request(a, h);
            cyc();
        end
        imemREN = 1'b0;
    endtask

    task automatic idle_cycle();
        imemREN  = 1'b0;
        imemaddr = $urandom;
        #1;
        chk("ihit_noreq", {31'b0, ihit}, 32'd0);
        chk("imemload_noreq", imemload, 32'd0);
        chk("iREN_noreq", {31'b0, iREN}, 32'd0);
        cyc();
    endtask

    task automatic chk_stats(input string tag);
`ifdef ICACHE_STATS_EN
        chk({tag, "_hits"}, hit_count, m_hits);
        chk({tag, "_misses"}, miss_count, m_miss);
`else
        imemaddr = imemaddr;
`endif
    endtask

    initial begin
        bit          h;
        logic [31:0] a;

        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
        m_clear();
        cyc();
        cyc();
        chk("rst_ihit", {31'b0, ihit}, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iREN", {31'b0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk_stats("rst");
        RST = 1'b0;
        cyc();

        // Cold miss with 3 wait cycles, then four re-requests.
        fetch(32'h40, 3);
        chk("cold_data", m_data[m_idx(32'h40)], 32'h8C220004);
        for (int i = 0; i < 4; i++) fetch(32'h40, 0);
        chk_stats("cold");

        // Conflict on index 0.
        fetch(32'h80, 2);
        fetch(32'h40, 1);

        // Redirect mid-fill: 0x100 completes, 0x200 is fetched afterwards.
        request(32'h100, h);
        cyc();
        imemaddr = 32'h200;
        fill(32'h100, 2);
        request(32'h200, h);
        cyc();
        if (!h) begin
            fill(32'h200, 1);
            request(32'h200, h);
            cyc();
        end
        imemREN = 1'b0;
        fetch(32'h100, 0);

        // imemREN dropped mid-fill: frame still installed.
        request(32'h2C4, h);
        cyc();
        imemREN = 1'b0;
        fill(32'h2C4, 2);
        fetch(32'h2C4, 0);

        // Wrap-around address and ignored offset bits.
        fetch(32'hFFFFFFFC, 1);
        fetch(32'hFFFFFFFF, 0);
        fetch(32'h0000003C, 1);
        fetch(32'hFFFFFFFD, 1);
        idle_cycle();

        // Reset in the middle of a fill.
        request(32'h300, h);
        cyc();
        iwait = 1'b1;
        #1;
        chk("prerst_iREN", {31'b0, iREN}, 32'd1);
        RST = 1'b1;
        #1;
        chk("midrst_iREN", {31'b0, iREN}, 32'd0);
        chk("midrst_iaddr", iaddr, 32'd0);
        chk("midrst_ihit", {31'b0, ihit}, 32'd0);
        m_clear();
        chk_stats("midrst");
        cyc();
        RST = 1'b0;
        imemREN = 1'b0;
        cyc();
        fetch(32'h40, 1);

        // Random traffic over a small address pool to mix hits, misses and conflicts.
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
            end else begin
                a = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                if ($urandom_range(0, 7) == 0) a = a | 32'hFFFFFE00;
                fetch(a, $urandom_range(0, 3));
            end
        end
        chk_stats("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
